// File: rtl/i2c_reg_reader_if.sv
// Host-side request/response bundle for the I2C register reader.
interface i2c_reg_reader_if #(
   parameter int MAX_BYTES = 2,
   parameter int NB_W      = 2
);
   logic                   start;
   logic [6:0]             dev_addr;
   logic [7:0]             reg_addr;
   logic                   use_ptr;
   logic [NB_W-1:0]        nbytes;
   logic                   busy;
   logic                   done;
   logic                   ack_err;
   logic [8*MAX_BYTES-1:0] rdata;

   modport master (output start, dev_addr, reg_addr, use_ptr, nbytes,
                   input  busy, done, ack_err, rdata);
   modport slave  (input  start, dev_addr, reg_addr, use_ptr, nbytes,
                   output busy, done, ack_err, rdata);
endinterface

// File: rtl/i2c_reg_reader.sv
// I2C master reading 1..MAX_BYTES bytes, optionally after writing a register pointer.
// Every bit/START/STOP is one CLK_DIV slot: SCL low Q0-Q1, high Q2-Q3; SDA moves at Q1, sampled at Q3.
module i2c_reg_reader #(
   parameter int CLK_DIV   = 200,
   parameter int MAX_BYTES = 2,
   parameter int NB_W      = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   i2c_reg_reader_if.slave host,
   output logic            scl,
   inout  wire             sda
);
   localparam int Q  = CLK_DIV / 4;
   localparam int CW = $clog2(CLK_DIV);
   localparam int RW = 8 * MAX_BYTES;

   typedef enum logic [3:0] {
      IDLE, START, ADDR_W, ACK_W, REG, ACK_R, RSTART, ADDR_R, ACK_A, READ, MACK, STOP
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      tx, rx;
   logic [6:0]      dev_q;
   logic [7:0]      reg_q;
   logic            ptr_q;
   logic [NB_W-1:0] left, nb_clamp;
   logic            nack, sda_oe, busy_q, done_q, ack_err_q;
   logic [RW-1:0]   rdata_q;
   logic            accept, slot_end, at_q1, at_q2, at_q3, last_bit, last_byte;

   // a start coinciding with the done pulse is dropped so the host sees a clean idle cycle
   assign accept    = (state == IDLE) && host.start && !done_q;
   assign slot_end  = (cnt == CW'(CLK_DIV - 1));
   assign at_q1     = (cnt == CW'(Q - 1));
   assign at_q2     = (cnt == CW'(2 * Q - 1));
   assign at_q3     = (cnt == CW'(3 * Q - 1));
   assign last_bit  = (bit_cnt == 3'd7);
   assign last_byte = (left == NB_W'(1));

   assign sda          = sda_oe ? 1'b0 : 1'bz;
   assign host.busy    = busy_q;
   assign host.done    = done_q;
   assign host.ack_err = ack_err_q;
   assign host.rdata   = rdata_q;

   always_comb begin
      nb_clamp = host.nbytes;
      if (host.nbytes == '0)
         nb_clamp = NB_W'(1);
      else if (host.nbytes > NB_W'(MAX_BYTES))
         nb_clamp = NB_W'(MAX_BYTES);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)              state_nx = START;
         START:   if (slot_end)            state_nx = ptr_q ? ADDR_W : ADDR_R;
         ADDR_W:  if (slot_end && last_bit) state_nx = ACK_W;
         ACK_W:   if (slot_end)            state_nx = nack ? STOP : REG;
         REG:     if (slot_end && last_bit) state_nx = ACK_R;
         ACK_R:   if (slot_end)            state_nx = nack ? STOP : RSTART;
         RSTART:  if (slot_end)            state_nx = ADDR_R;
         ADDR_R:  if (slot_end && last_bit) state_nx = ACK_A;
         ACK_A:   if (slot_end)            state_nx = nack ? STOP : READ;
         READ:    if (slot_end && last_bit) state_nx = MACK;
         MACK:    if (slot_end)            state_nx = last_byte ? STOP : READ;
         STOP:    if (slot_end)            state_nx = IDLE;
         default:                          state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         bit_cnt   <= '0;
         tx        <= '0;
         rx        <= '0;
         dev_q     <= '0;
         reg_q     <= '0;
         ptr_q     <= 1'b0;
         left      <= '0;
         nack      <= 1'b0;
         sda_oe    <= 1'b0;
         scl       <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE) begin
            cnt <= '0;
            if (accept) begin
               dev_q     <= host.dev_addr;
               reg_q     <= host.reg_addr;
               ptr_q     <= host.use_ptr;
               left      <= nb_clamp;
               tx        <= {host.dev_addr, ~host.use_ptr};
               bit_cnt   <= '0;
               nack      <= 1'b0;
               busy_q    <= 1'b1;
               ack_err_q <= 1'b0;
               rdata_q   <= '0;
               scl       <= 1'b0;
            end
         end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (at_q1) begin
               case (state)
                  ADDR_W, REG, ADDR_R: sda_oe <= ~tx[7];
                  MACK:                sda_oe <= ~last_byte;
                  STOP:                sda_oe <= 1'b1;
                  default:             sda_oe <= 1'b0;
               endcase
            end
            if (at_q2) scl <= 1'b1;
            if (at_q3) begin
               case (state)
                  START, RSTART: sda_oe <= 1'b1;
                  STOP:          sda_oe <= 1'b0;
                  ACK_W, ACK_R, ACK_A: begin
                     nack <= sda;
                     if (sda) ack_err_q <= 1'b1;
                  end
                  READ:          rx <= {rx[6:0], sda};
                  default: ;
               endcase
            end
            if (slot_end) begin
               // SCL parks high once the STOP slot closes
               scl <= (state == STOP);
               case (state)
                  ADDR_W, REG, ADDR_R, READ: begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= {tx[6:0], 1'b0};
                  end
                  ACK_W:  tx <= reg_q;
                  RSTART: tx <= {dev_q, 1'b1};
                  MACK: begin
                     rdata_q <= (rdata_q << 8) | RW'(rx);
                     left    <= left - 1'b1;
                  end
                  STOP: begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_reg_reader.sv
// Directed bench: behavioural I2C slave at 7'h48 plus bus monitor around i2c_reg_reader.
module tb_i2c_reg_reader;
   localparam int CLK_DIV   = 8;
   localparam int MAX_BYTES = 2;
   localparam int NB_W      = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic scl;
   wire  sda;
   logic s_drv = 1'b0;
   logic sda_l;

   i2c_reg_reader_if #(.MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) host ();

   i2c_reg_reader #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .NB_W(NB_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .host  (host),
      .scl   (scl),
      .sda   (sda)
   );

   pullup (sda);
   assign sda   = (s_drv && rst_n) ? 1'b0 : 1'bz;
   assign sda_l = (sda === 1'b0) ? 1'b0 : 1'b1;

   always #5 clk = ~clk;

   // slave configuration and observation logs
   logic [6:0] slv_addr = 7'h48;
   logic       slv_present = 1'b1;
   logic       slv_nack_reg = 1'b0;
   logic [7:0] slv_data [4];
   logic [7:0] wlog [$];
   logic       mack_log [$];
   int n_start = 0, n_stop = 0, n_glitch = 0;

   int   mode = 0, rc = 0, idx = 0;
   logic [7:0] sh = '0;
   logic is_addr = 1'b0, rw = 1'b0, acked = 1'b0, mack = 1'b0;
   logic scl_p = 1'b1, sda_p = 1'b1;

   // slave reacts on the falling clk edge so it never races the DUT's sampling edge
   always @(negedge clk) begin
      logic cs, rise, fall;
      if (!rst_n) begin
         mode = 0; s_drv = 1'b0; scl_p = 1'b1; sda_p = 1'b1;
      end else begin
         cs   = sda_l;
         rise = scl && !scl_p;
         fall = !scl && scl_p;
         if ((scl != scl_p) && (cs != sda_p)) n_glitch++;
         if (scl && scl_p && sda_p && !cs) begin
            n_start++; mode = 1; rc = 0; is_addr = 1'b1; s_drv = 1'b0;
         end else if (scl && scl_p && !sda_p && cs) begin
            n_stop++; mode = 0; s_drv = 1'b0;
         end else if (mode == 1) begin
            if (rise) begin
               if (rc < 8) sh = {sh[6:0], cs};
               rc++;
            end else if (fall) begin
               if (rc == 8) begin
                  wlog.push_back(sh);
                  if (is_addr) begin
                     rw = sh[0];
                     acked = slv_present && (sh[7:1] == slv_addr);
                  end else acked = !slv_nack_reg;
                  s_drv = acked;
               end else if (rc == 9) begin
                  s_drv = 1'b0; rc = 0;
                  if (!acked) mode = 0;
                  else if (is_addr && rw) begin
                     mode = 2; idx = 0; s_drv = ~slv_data[0][7];
                  end
                  is_addr = 1'b0;
               end
            end
         end else if (mode == 2) begin
            if (rise) begin
               if (rc == 8) mack = cs;
               rc++;
            end else if (fall) begin
               if (rc < 8) s_drv = ~slv_data[idx][7-rc];
               else if (rc == 8) s_drv = 1'b0;
               else begin
                  mack_log.push_back(mack); rc = 0;
                  if (!mack) begin idx++; s_drv = ~slv_data[idx][7]; end
                  else begin mode = 0; s_drv = 1'b0; end
               end
            end
         end
         scl_p = scl;
         sda_p = cs;
      end
   end

   int vectors = 0, miscompares = 0;
   int dur, wb, mb, sb, pb, gb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // duration check with the one-cycle latch tolerance; prints the raw count on failure
   task automatic chk_dur(input string tag, input int slots);
      int e;
      e = slots * CLK_DIV;
      chk(tag, (dur >= e - 1 && dur <= e + 1) ? e : dur, e);
   endtask

   task automatic run(input string tag, input logic [6:0] dev, input logic [7:0] ra,
                      input logic up, input logic [NB_W-1:0] nb, input int poke, input logic b2b);
      wb = wlog.size(); mb = mack_log.size(); sb = n_start; pb = n_stop; gb = n_glitch;
      @(negedge clk);
      host.dev_addr = dev; host.reg_addr = ra; host.use_ptr = up; host.nbytes = nb;
      host.start = 1'b1;
      @(negedge clk);
      host.start = 1'b0;
      dur = 0;
      while (!host.done && dur < 2000) begin
         @(negedge clk);
         dur++;
         if (dur == poke) begin
            host.start = 1'b1; host.dev_addr = 7'h11; host.use_ptr = ~up;
         end else host.start = 1'b0;
      end
      chk({tag, "_done_seen"}, host.done, 1'b1);
      chk({tag, "_busy_at_done"}, host.busy, 1'b0);
      if (b2b) host.start = 1'b1;
      @(negedge clk);
      chk({tag, "_done_pulse"}, host.done, 1'b0);
      if (b2b) begin
         chk({tag, "_b2b_ignored"}, host.busy, 1'b0);
         @(negedge clk);
         host.start = 1'b0;
         chk({tag, "_b2b_accepted"}, host.busy, 1'b1);
      end
   endtask

   initial begin
      host.start = 1'b0; host.dev_addr = '0; host.reg_addr = '0;
      host.use_ptr = 1'b0; host.nbytes = '0;
      slv_data[0] = 8'h19; slv_data[1] = 8'h80; slv_data[2] = 8'hA5; slv_data[3] = 8'h3C;
      repeat (3) @(negedge clk);
      chk("rst_scl", scl, 1'b1);
      chk("rst_sda", sda_l, 1'b1);
      chk("rst_busy", host.busy, 1'b0);
      chk("rst_done", host.done, 1'b0);
      chk("rst_ack_err", host.ack_err, 1'b0);
      chk("rst_rdata", host.rdata, 16'h0000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run("t1", 7'h48, 8'h00, 1'b0, 2'd2, 0, 1'b0);
      chk("t1_wbytes", wlog.size() - wb, 1);
      chk("t1_addr", wlog[wb], 8'h91);
      chk("t1_rdata", host.rdata, 16'h1980);
      chk("t1_ack_err", host.ack_err, 1'b0);
      chk_dur("t1_dur", 29);
      chk("t1_mack_n", mack_log.size() - mb, 2);
      chk("t1_mack0", mack_log[mb], 1'b0);
      chk("t1_mack1", mack_log[mb+1], 1'b1);
      chk("t1_starts", n_start - sb, 1);
      chk("t1_stops", n_stop - pb, 1);
      chk("t1_glitch", n_glitch - gb, 0);

      run("t2", 7'h48, 8'h03, 1'b1, 2'd1, 0, 1'b0);
      chk("t2_wbytes", wlog.size() - wb, 3);
      chk("t2_w0", wlog[wb], 8'h90);
      chk("t2_w1", wlog[wb+1], 8'h03);
      chk("t2_w2", wlog[wb+2], 8'h91);
      chk("t2_starts", n_start - sb, 2);
      chk("t2_rdata", host.rdata, 16'h0019);
      chk_dur("t2_dur", 39);
      chk("t2_mack", mack_log[mb], 1'b1);

      slv_present = 1'b0;
      run("t3", 7'h48, 8'h03, 1'b1, 2'd2, 0, 1'b0);
      chk("t3_ack_err", host.ack_err, 1'b1);
      chk("t3_rdata", host.rdata, 16'h0000);
      chk_dur("t3_dur", 11);
      chk("t3_stops", n_stop - pb, 1);
      chk("t3_wbytes", wlog.size() - wb, 1);
      slv_present = 1'b1;

      slv_nack_reg = 1'b1;
      run("t4", 7'h48, 8'h03, 1'b1, 2'd2, 0, 1'b0);
      chk("t4_ack_err", host.ack_err, 1'b1);
      chk("t4_starts", n_start - sb, 1);
      chk("t4_stops", n_stop - pb, 1);
      chk_dur("t4_dur", 20);
      chk("t4_wbytes", wlog.size() - wb, 2);
      slv_nack_reg = 1'b0;

      run("t5", 7'h48, 8'h00, 1'b0, 2'd0, 0, 1'b0);
      chk("t5_rdata", host.rdata, 16'h0019);
      chk("t5_ack_err", host.ack_err, 1'b0);
      chk_dur("t5_dur", 20);
      chk("t5_mack_n", mack_log.size() - mb, 1);

      run("t6", 7'h48, 8'h00, 1'b0, 2'd3, 50, 1'b0);
      chk("t6_rdata", host.rdata, 16'h1980);
      chk_dur("t6_dur", 29);
      chk("t6_addr", wlog[wb], 8'h91);
      chk("t6_starts", n_start - sb, 1);
      chk("t6_glitch", n_glitch - gb, 0);

      run("t7", 7'h48, 8'h00, 1'b0, 2'd2, 0, 1'b1);
      dur = 0;
      while (!host.done && dur < 2000) begin
         @(negedge clk);
         dur++;
      end
      chk("t7_done_seen", host.done, 1'b1);
      chk("t7_rdata", host.rdata, 16'h1980);

      // reset in the middle of the first data byte
      @(negedge clk);
      host.dev_addr = 7'h48; host.use_ptr = 1'b0; host.nbytes = 2'd2; host.start = 1'b1;
      @(negedge clk);
      host.start = 1'b0;
      repeat (104) @(negedge clk);
      chk("t8_in_read", host.busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t8_scl", scl, 1'b1);
      chk("t8_sda", sda_l, 1'b1);
      chk("t8_busy", host.busy, 1'b0);
      chk("t8_rdata", host.rdata, 16'h0000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run("t9", 7'h48, 8'h00, 1'b0, 2'd2, 0, 1'b0);
      chk("t9_rdata", host.rdata, 16'h1980);
      chk("t9_ack_err", host.ack_err, 1'b0);
      chk_dur("t9_dur", 29);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/i2c_reg_reader.md
Name: i2c_reg_reader

Overview:
- Parametrised I2C master for reading sensor registers; next generation of the fixed two-byte temperature reader.
- Host supplies 7-bit device address, optional 8-bit register pointer (written first, then repeated START) and a byte count of 1..MAX_BYTES.
- True open-drain SDA; SCL held high when idle; ACK checking with error flag; start/busy/done handshake instead of a free-running poll timer.
- Sits between a board sensor (e.g. LM75A at 7'h48) and display/control logic.

Parameters:
- CLK_DIV, 200: clk cycles per SCL bit slot; multiple of 4, >= 8 (200 -> 250 kHz SCL at 50 MHz).
- MAX_BYTES, 2: maximum bytes per read; rdata width is 8*MAX_BYTES.
- NB_W, 2: width of nbytes; must hold MAX_BYTES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; ignored while busy=1
- dev_addr  in  7  slave address, latched on accepted start
- reg_addr  in  8  register pointer, latched on accepted start
- use_ptr  in  1  1: write reg_addr, then repeated START and read; 0: read only. Latched on accepted start.
- nbytes  in  NB_W  bytes to read; latched on accepted start
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  slave NACKed an address or pointer byte during the last transaction
- rdata  out  8*MAX_BYTES  received data
- scl  out  1  SCL, push-pull, no clock stretching
- sda  inout  1  open-drain: driven 0 or released (z); never driven 1

Behaviour:
- Reset values: scl=1, sda released, busy=0, done=0, ack_err=0, rdata=0, state IDLE. Reset mid-transaction aborts immediately with no STOP generated.
- Slot timing: every bit, START or STOP occupies one slot of CLK_DIV cycles, split into quarters Q0..Q3 of CLK_DIV/4 cycles each.
  - SCL is low in Q0-Q1 and high in Q2-Q3.
  - SDA changes at the start of Q1.
  - SDA is sampled at the start of Q3.
- START / repeated START slot: SDA released at Q1; SDA pulled low at Q3 while SCL is high.
- STOP slot: SDA pulled low at Q1; SDA released at Q3. SCL then stays high in IDLE.
- Start acceptance: start=1 in IDLE latches the inputs, sets busy=1 on the next cycle, clears ack_err, clears rdata to 0 and starts slot timing at Q0.
- Byte count clamping: nbytes=0 is treated as 1; nbytes>MAX_BYTES is clamped to MAX_BYTES.
- FSM: IDLE -> START -> ADDR_W (8 bits: dev_addr, R/W=0) -> ACK_W -> REG (8 bits) -> ACK_R -> RSTART -> ADDR_R (dev_addr, R/W=1) -> ACK_A -> READ (8 bits) -> MACK -> [READ ... | STOP] -> IDLE.
  - If use_ptr=0: START goes directly to ADDR_R.
- Bit order: all bytes are sent and received MSB first.
- ACK slots (ACK_W, ACK_R, ACK_A): SDA is released and sampled at Q3. If sampled 1, set ack_err=1 and go to STOP; no further bytes are sent or read.
- Data slots: each received byte is shifted into rdata from the LSB end (rdata <= {rdata[8*MAX_BYTES-9:0], byte}).
  - First byte ends up most significant among the received bytes; unused upper bytes are 0.
  - With 2 bytes: rdata = {MSB, LSB}.
- MACK slot: master drives SDA=0 (ACK) after every byte except the last, which gets NACK (SDA released). After the last byte's NACK slot, go to STOP.
- Completion: done pulses for one cycle at the end of the STOP slot; busy drops in the same cycle. rdata and ack_err hold until the next accepted start.
- Slot count:
  - use_ptr=0: 1 + 9 + 9*n + 1.
  - use_ptr=1: 1 + 9 + 9 + 1 + 9 + 9*n + 1.
  - On NACK: the slots up to and including the failing ACK, plus 1 for STOP.
  - Transaction duration = slot count * CLK_DIV cycles, ±1 cycle for start latch.
- Back-to-back: start asserted in the same cycle as done is ignored; start in the following cycle is accepted.

Test Plan:
- CLK_DIV=8, slave model at 7'h48 returning 8'h19, 8'h80; start with use_ptr=0, nbytes=2 -> bus shows address byte 8'h91; rdata=16'h1980; ack_err=0; done after 29 slots (232 +/-1 cycles); master ACKs byte 1 and NACKs byte 2.
- use_ptr=1, reg_addr=8'h03, nbytes=1 -> bus shows 8'h90, 8'h03, repeated START, 8'h91; rdata=16'h0019; 39 slots.
- No slave present (SDA stays high) -> ack_err=1 after the first ACK slot; STOP issued; done pulses; rdata=0; duration 11 slots.
- Slave NACKs the pointer byte -> ack_err=1; no repeated START; STOP follows.
- nbytes=0 -> 1 byte read; nbytes=3 with MAX_BYTES=2 -> 2 bytes read. A second start pulse while busy -> ignored, with no glitch on scl/sda.
- Assert rst_n low mid-READ -> next cycle scl=1, sda released, busy=0, rdata=0. A subsequent start completes normally. Bus monitor checks that SDA changes only while SCL is low, except for START/STOP.
